// File: rtl/controller_port.sv
`default_nettype none
// ============================================================================
// Module   : controller_port
// Brief    : Two-player NES joypad emulator at $4016/$4017 with a
//            strobe/serial-shift CPU interface fed by USB HID keycodes.
// Revision : 1.0 - initial release
// ============================================================================
module controller_port #(
    parameter logic [63:0] P1_MAP = 64'h07_04_16_1A_28_2C_0E_0D,
    parameter logic [63:0] P2_MAP = 64'h4F_50_51_52_58_57_5A_5B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        addr,
    input  logic        rw,
    input  logic [31:0] keycode,
    inout  wire  [7:0]  cpubus,
    output logic [7:0]  buttons_p1,
    output logic [7:0]  buttons_p2
);

    localparam logic [6:0] c_OPEN_BUS = 7'b0100000;

    logic [31:0] sync1_q, sync2_q;
    logic [7:0]  btn1_q, btn1_d, btn2_q, btn2_d;
    logic [7:0]  sr1_q, sr1_d, sr2_q, sr2_d;
    logic        strobe_q, strobe_d;
    logic        prev_read_q, prev_addr_q;
    logic        w_read_acc, w_acc_end, w_rd_bit;

    // A map byte of zero marks an unused button and must never match an empty slot.
    function automatic logic [7:0] decode(input logic [63:0] map, input logic [31:0] keys);
        logic [7:0] hit;
        hit = 8'h00;
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 4; k++) begin
                if (map[8*n +: 8] != 8'h00 && keys[8*k +: 8] == map[8*n +: 8]) begin
                    hit[n] = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    assign w_read_acc = !cs && rw;
    assign w_acc_end  = prev_read_q && (!w_read_acc || (addr != prev_addr_q));
    assign w_rd_bit   = addr ? sr2_q[0] : sr1_q[0];

    always_comb begin
        btn1_d   = decode(P1_MAP, sync2_q);
        btn2_d   = decode(P2_MAP, sync2_q);
        sr1_d    = sr1_q;
        sr2_d    = sr2_q;
        strobe_d = strobe_q;
        // Reload takes priority over a pending shift.
        if (strobe_q) begin
            sr1_d = btn1_q;
            sr2_d = btn2_q;
        end else if (w_acc_end) begin
            if (prev_addr_q) begin
                sr2_d = {1'b1, sr2_q[7:1]};
            end else begin
                sr1_d = {1'b1, sr1_q[7:1]};
            end
        end
        if (!cs && !rw && !addr) begin
            strobe_d = cpubus[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 32'h0;
            sync2_q     <= 32'h0;
            btn1_q      <= 8'h00;
            btn2_q      <= 8'h00;
            sr1_q       <= 8'h00;
            sr2_q       <= 8'h00;
            strobe_q    <= 1'b0;
            prev_read_q <= 1'b0;
            prev_addr_q <= 1'b0;
        end else begin
            sync1_q     <= keycode;
            sync2_q     <= sync1_q;
            btn1_q      <= btn1_d;
            btn2_q      <= btn2_d;
            sr1_q       <= sr1_d;
            sr2_q       <= sr2_d;
            strobe_q    <= strobe_d;
            prev_read_q <= w_read_acc;
            prev_addr_q <= addr;
        end
    end

    // Gating with rst_n releases the bus immediately on reset, without a clock.
    assign cpubus     = (rst_n && w_read_acc) ? {c_OPEN_BUS, w_rd_bit} : 8'hzz;
    assign buttons_p1 = btn1_q;
    assign buttons_p2 = btn2_q;

endmodule
`default_nettype wire

// File: tb/tb_controller_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_controller_port
// Brief    : Directed self-checking bench for controller_port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_controller_port;

    logic        clk = 1'b0;
    logic        rst_n, cs, addr, rw;
    logic [31:0] keycode;
    logic [7:0]  tb_bus;
    logic        tb_drv;
    wire  [7:0]  cpubus;
    logic [7:0]  buttons_p1, buttons_p2;
    int          checks = 0;
    int          failures = 0;

    // The bench parks a known value on the bus whenever the DUT should be released.
    localparam logic [7:0] c_PARK = 8'hA5;

    assign cpubus = tb_drv ? tb_bus : 8'hzz;

    controller_port dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs         (cs),
        .addr       (addr),
        .rw         (rw),
        .keycode    (keycode),
        .cpubus     (cpubus),
        .buttons_p1 (buttons_p1),
        .buttons_p2 (buttons_p2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%02h expected=%02h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic a, input logic [7:0] exp, input string tag);
        @(negedge clk);
        tb_drv = 1'b0; cs = 1'b0; rw = 1'b1; addr = a;
        #2 check(tag, cpubus, exp);
        @(negedge clk);
        cs = 1'b1; tb_bus = c_PARK; tb_drv = 1'b1;
        #2 check({tag, "_idle"}, cpubus, c_PARK);
    endtask

    // Back-to-back reads of $4016 then $4017; the address change ends the first access.
    task automatic rd_pair(input logic [7:0] exp1, input logic [7:0] exp2);
        @(negedge clk);
        tb_drv = 1'b0; cs = 1'b0; rw = 1'b1; addr = 1'b0;
        #2 check("pair_p1", cpubus, exp1);
        @(negedge clk);
        addr = 1'b1;
        #2 check("pair_p2", cpubus, exp2);
        @(negedge clk);
        cs = 1'b1; tb_bus = c_PARK; tb_drv = 1'b1;
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        @(negedge clk);
        cs = 1'b0; rw = 1'b0; addr = a; tb_bus = d; tb_drv = 1'b1;
        @(negedge clk);
        cs = 1'b1; rw = 1'b1; tb_bus = c_PARK;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got=%0d expected=%0d", 0, 1);
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0] exp_seq;
        rst_n = 1'b0; cs = 1'b1; addr = 1'b0; rw = 1'b1;
        keycode = 32'h0; tb_bus = c_PARK; tb_drv = 1'b1;
        #2;
        check("rst_p1", buttons_p1, 8'h00);
        check("rst_p2", buttons_p2, 8'h00);
        check("rst_bus", cpubus, c_PARK);
        @(negedge clk) rst_n = 1'b1;

        // Empty register shifts in ones after eight reads.
        for (int i = 0; i < 10; i++) rd(1'b0, (i < 8) ? 8'h40 : 8'h41, "reset_read");

        // J + Enter: three-edge latency into buttons_p1.
        @(negedge clk) keycode = 32'h0000_0D28;
        tick(2);
        check("lat2_p1", buttons_p1, 8'h00);
        tick(1);
        check("lat3_p1", buttons_p1, 8'h09);
        check("lat3_p2", buttons_p2, 8'h00);
        wr(1'b0, 8'h01);
        wr(1'b0, 8'h00);
        exp_seq = 8'h09;
        for (int i = 0; i < 8; i++) rd(1'b0, {7'b0100000, exp_seq[i]}, "latch_seq");
        rd(1'b0, 8'h41, "latch_exh");
        rd(1'b0, 8'h41, "latch_exh2");
        // Writing $4017 with strobe low must not start a reload of released keys.
        @(negedge clk) keycode = 32'h0;
        tick(4);
        wr(1'b1, 8'h01);
        rd(1'b0, 8'h41, "w4017_nostrobe");

        // Two players: Right on P2, B on P1.
        @(negedge clk) keycode = 32'h4F_00_0E_00;
        tick(4);
        check("two_p1", buttons_p1, 8'h02);
        check("two_p2", buttons_p2, 8'h80);
        wr(1'b0, 8'h01);
        wr(1'b0, 8'h00);
        for (int i = 0; i < 8; i++) rd(1'b1, (i == 7) ? 8'h41 : 8'h40, "two_p2_seq");
        for (int i = 0; i < 8; i++) rd(1'b0, (i == 1) ? 8'h41 : 8'h40, "two_p1_seq");
        wr(1'b0, 8'h01);
        wr(1'b0, 8'h00);
        for (int i = 0; i < 8; i++) rd_pair((i == 1) ? 8'h41 : 8'h40, (i == 7) ? 8'h41 : 8'h40);
        rd(1'b0, 8'h41, "pair_exh_p1");
        rd(1'b1, 8'h41, "pair_exh_p2");

        // Stalled read shifts once.
        @(negedge clk) keycode = 32'h0000_000D;
        tick(4);
        wr(1'b0, 8'h01);
        wr(1'b0, 8'h00);
        @(negedge clk);
        tb_drv = 1'b0; cs = 1'b0; rw = 1'b1; addr = 1'b0;
        repeat (5) begin
            #2 check("stall", cpubus, 8'h41);
            @(negedge clk);
        end
        cs = 1'b1; tb_drv = 1'b1;
        rd(1'b0, 8'h40, "stall_next");
        rd(1'b0, 8'h40, "stall_next2");

        // Strobe held high: reads follow live A, no shift; $4017 write leaves strobe set.
        wr(1'b0, 8'h01);
        rd(1'b0, 8'h41, "hold_a1");
        rd(1'b0, 8'h41, "hold_a2");
        @(negedge clk) keycode = 32'h0;
        tick(4);
        rd(1'b0, 8'h40, "hold_none1");
        rd(1'b0, 8'h40, "hold_none2");
        wr(1'b1, 8'h00);
        @(negedge clk) keycode = 32'h0000_000D;
        tick(4);
        rd(1'b0, 8'h41, "hold_w4017_a");
        rd(1'b0, 8'h41, "hold_w4017_b");

        // Asynchronous reset in the middle of a read, strobe still high.
        @(negedge clk);
        tb_drv = 1'b0; cs = 1'b0; rw = 1'b1; addr = 1'b0;
        #2 check("ar_pre", cpubus, 8'h41);
        #1 rst_n = 1'b0;
        tb_drv = 1'b1; tb_bus = c_PARK;
        #1;
        check("ar_bus", cpubus, c_PARK);
        check("ar_p1", buttons_p1, 8'h00);
        check("ar_p2", buttons_p2, 8'h00);
        @(negedge clk);
        cs = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        tick(4);
        check("ar_rel_p1", buttons_p1, 8'h01);
        rd(1'b0, 8'h40, "ar_strobe0_a");
        rd(1'b0, 8'h40, "ar_strobe0_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
